// File: rtl/mos6502_decode_sweeper.sv
// Wishbone-programmed sweeper that steps the 6502 decoder through an opcode range,
// folding each decoded word into a rotating signature and counting opcodes with a mnemonic.
module mos6502_decode_sweeper #(
   parameter logic [31:0] BASE_ADDR = 32'h3000_0010
) (
   input  logic        wb_clk_i,
   input  logic        wb_rst_i,
   input  logic        wbs_stb_i,
   input  logic        wbs_cyc_i,
   input  logic        wbs_we_i,
   input  logic [3:0]  wbs_sel_i,
   input  logic [31:0] wbs_dat_i,
   input  logic [31:0] wbs_adr_i,
   output logic        wbs_ack_o,
   output logic [31:0] wbs_dat_o,
   output logic [7:0]  dec_instr_o,
   input  logic [65:0] dec_word_i
);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_DRIVE  = 2'd1,
      ST_SAMPLE = 2'd2
   } state_t;

   function automatic logic [65:0] sig_fold(input logic [65:0] sig, input logic [65:0] word);
      sig_fold = {sig[64:0], sig[65]} ^ word;
   endfunction

   state_t      state_r;
   state_t      state_nxt_s;
   logic        ack_r;
   logic [31:0] dat_r;
   logic [7:0]  instr_r;
   logic [7:0]  first_r;
   logic [7:0]  last_r;
   logic [7:0]  cur_r;
   logic [65:0] sig_r;
   logic [8:0]  cnt_r;
   logic        done_r;
   logic        err_r;
   logic        cmd_vld_r;
   logic        cmd_start_r;
   logic        cmd_abort_r;
   logic [7:0]  cmd_first_r;
   logic [7:0]  cmd_last_r;
   logic [31:0] off_s;
   logic        hit_s;
   logic [2:0]  reg_idx_s;
   logic        accept_s;
   logic        start_s;
   logic        abort_s;
   logic        range_ok_s;
   logic        at_last_s;
   logic        busy_s;
   logic [31:0] rdata_s;
   logic        unused_s;

   assign off_s     = wbs_adr_i - BASE_ADDR;
   assign hit_s     = (off_s < 32'd24);
   assign reg_idx_s = off_s[4:2];
   assign accept_s  = wbs_stb_i & wbs_cyc_i & ~ack_r & hit_s;

   // CTRL writes are registered first, so the FSM reacts one cycle after the accept edge
   assign start_s    = cmd_vld_r & cmd_start_r & ~cmd_abort_r;
   assign abort_s    = cmd_vld_r & cmd_abort_r;
   assign range_ok_s = (cmd_first_r <= cmd_last_r);
   assign at_last_s  = (cur_r == last_r);
   assign busy_s     = (state_r != ST_IDLE);

   assign wbs_ack_o   = ack_r;
   assign wbs_dat_o   = dat_r;
   assign dec_instr_o = instr_r;
   assign unused_s    = ^{wbs_sel_i, wbs_dat_i[31:24], wbs_dat_i[7:2]};

   // Latch accepted CTRL writes as a one-cycle command
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         cmd_vld_r   <= 1'b0;
         cmd_start_r <= 1'b0;
         cmd_abort_r <= 1'b0;
         cmd_first_r <= 8'h00;
         cmd_last_r  <= 8'h00;
      end else begin
         cmd_vld_r   <= accept_s & wbs_we_i & (reg_idx_s == 3'd0);
         cmd_start_r <= wbs_dat_i[0];
         cmd_abort_r <= wbs_dat_i[1];
         cmd_first_r <= wbs_dat_i[15:8];
         cmd_last_r  <= wbs_dat_i[23:16];
      end
   end

   // FSM state register
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // FSM next-state logic
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (start_s && range_ok_s) begin
               state_nxt_s = ST_DRIVE;
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_DRIVE: begin
            if (abort_s) begin
               state_nxt_s = ST_IDLE;
            end else begin
               state_nxt_s = ST_SAMPLE;
            end
         end
         ST_SAMPLE: begin
            if (abort_s || at_last_s) begin
               state_nxt_s = ST_IDLE;
            end else begin
               state_nxt_s = ST_DRIVE;
            end
         end
         default: state_nxt_s = ST_IDLE;
      endcase
   end

   // Sweep datapath: range setup, opcode drive, signature fold and valid count
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         instr_r <= 8'h00;
         first_r <= 8'h00;
         last_r  <= 8'h00;
         cur_r   <= 8'h00;
         sig_r   <= 66'h0;
         cnt_r   <= 9'd0;
         done_r  <= 1'b0;
         err_r   <= 1'b0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (cmd_vld_r) begin
                  first_r <= cmd_first_r;
                  last_r  <= cmd_last_r;
               end
               if (start_s && range_ok_s) begin
                  cur_r  <= cmd_first_r;
                  sig_r  <= 66'h0;
                  cnt_r  <= 9'd0;
                  done_r <= 1'b0;
                  err_r  <= 1'b0;
               end else if (start_s) begin
                  err_r  <= 1'b1;
                  done_r <= 1'b1;
               end
            end
            ST_DRIVE: begin
               instr_r <= cur_r;
            end
            ST_SAMPLE: begin
               sig_r <= sig_fold(sig_r, dec_word_i);
               if (|dec_word_i[55:0]) begin
                  cnt_r <= cnt_r + 9'd1;
               end
               // Stop on LAST without incrementing, so a 0xFF end never wraps
               if (at_last_s) begin
                  done_r <= ~abort_s;
               end else begin
                  cur_r <= cur_r + 8'd1;
               end
            end
            default: begin
               cur_r <= cur_r;
            end
         endcase
      end
   end

   // Register read mux
   always_comb begin
      rdata_s = 32'h0;
      case (reg_idx_s)
         3'd0:    rdata_s = {8'h00, last_r, first_r, 8'h00};
         3'd1:    rdata_s = {7'h00, cnt_r, cur_r, 5'h00, err_r, done_r, busy_s};
         3'd2:    rdata_s = sig_r[31:0];
         3'd3:    rdata_s = sig_r[63:32];
         3'd4:    rdata_s = {30'h0, sig_r[65:64]};
         default: rdata_s = 32'h0;
      endcase
   end

   // Wishbone acknowledge and read data, one-cycle ack per accepted access
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         ack_r <= 1'b0;
         dat_r <= 32'h0;
      end else begin
         ack_r <= accept_s;
         if (accept_s && !wbs_we_i) begin
            dat_r <= rdata_s;
         end else begin
            dat_r <= 32'h0;
         end
      end
   end

endmodule

// File: tb/tb_mos6502_decode_sweeper.sv
// Directed bench for mos6502_decode_sweeper with a stub decoder and a cycle-indexed sweep model.
module tb_mos6502_decode_sweeper;

   localparam logic [31:0] BASE   = 32'h3000_0010;
   localparam logic [31:0] A_CTRL = BASE;
   localparam logic [31:0] A_STAT = BASE + 32'h4;
   localparam logic [31:0] A_SLO  = BASE + 32'h8;
   localparam logic [31:0] A_SMID = BASE + 32'hC;
   localparam logic [31:0] A_SHI  = BASE + 32'h10;
   localparam logic [31:0] A_RSV  = BASE + 32'h14;
   localparam int          FAR    = 1 << 30;

   logic        wb_clk_i = 1'b0;
   logic        wb_rst_i = 1'b1;
   logic        wbs_stb_i = 1'b0;
   logic        wbs_cyc_i = 1'b0;
   logic        wbs_we_i = 1'b0;
   logic [3:0]  wbs_sel_i = 4'hF;
   logic [31:0] wbs_dat_i = 32'h0;
   logic [31:0] wbs_adr_i = 32'h0;
   logic        wbs_ack_o;
   logic [31:0] wbs_dat_o;
   logic [7:0]  dec_instr_o;
   logic [65:0] dec_word_i;

   assign dec_word_i = {58'h0, dec_instr_o};

   mos6502_decode_sweeper #(.BASE_ADDR(BASE)) dut (
      .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i),
      .wbs_stb_i(wbs_stb_i), .wbs_cyc_i(wbs_cyc_i), .wbs_we_i(wbs_we_i),
      .wbs_sel_i(wbs_sel_i), .wbs_dat_i(wbs_dat_i), .wbs_adr_i(wbs_adr_i),
      .wbs_ack_o(wbs_ack_o), .wbs_dat_o(wbs_dat_o),
      .dec_instr_o(dec_instr_o), .dec_word_i(dec_word_i)
   );

   always #5 wb_clk_i = ~wb_clk_i;

   int total = 0;
   int bad = 0;
   int cyc_n = 0;
   int acc_cyc = 0;
   logic chk_en = 1'b0;

   // Sweep model: start edge, range, and the edge after which an abort freezes the opcode
   logic       m_active = 1'b0;
   logic [7:0] m_prev = 8'h00;
   int         m_start = 0;
   int         m_first = 0;
   int         m_n = 1;
   int         m_stop = FAR;

   task automatic chk(input string nm, input logic [65:0] act, input logic [65:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc_n);
      end
   endtask

   // Opcode j of the sweep appears on the edge start+2+2j and then holds
   function automatic logic [7:0] exp_instr(input int c);
      int e;
      int k;
      if (!m_active) return m_prev;
      e = (c < m_stop) ? c : m_stop;
      if (e < m_start + 2) return m_prev;
      k = (e - m_start - 2) / 2;
      if (k > m_n - 1) k = m_n - 1;
      return 8'(m_first + k);
   endfunction

   // STATUS as seen after edge e of an un-aborted sweep; opcode j is folded on edge start+3+2j
   function automatic logic [31:0] exp_status(input int e);
      int s;
      logic busy;
      logic done;
      logic [7:0] cur;
      logic [8:0] cnt;
      s = (e - m_start - 1) / 2;
      if (s > m_n) s = m_n;
      busy = (e >= m_start + 1) && (e < m_start + 1 + 2 * m_n);
      done = (e >= m_start + 1 + 2 * m_n);
      cur  = 8'(m_first + ((s < m_n) ? s : m_n - 1));
      cnt  = 9'(s - ((m_first == 0 && s > 0) ? 1 : 0));
      return {7'h00, cnt, cur, 5'h00, 1'b0, done, busy};
   endfunction

   function automatic logic [65:0] sweep_sig(input int first, input int n);
      logic [65:0] s;
      s = 66'h0;
      for (int i = 0; i < n; i++) s = {s[64:0], s[65]} ^ {58'h0, 8'(first + i)};
      return s;
   endfunction

   // Every-cycle check of the decoder drive against the model
   always begin
      @(posedge wb_clk_i);
      cyc_n = cyc_n + 1;
      #1;
      if (chk_en) chk("dec_instr", {58'h0, dec_instr_o}, {58'h0, exp_instr(cyc_n)});
   end

   task automatic wb_xfer(input logic we, input logic [31:0] adr, input logic [31:0] wdat,
                          input logic [3:0] sel, output logic [31:0] rdat, output logic acked);
      acked = 1'b0;
      rdat = 32'h0;
      wbs_stb_i = 1'b1; wbs_cyc_i = 1'b1; wbs_we_i = we;
      wbs_adr_i = adr; wbs_dat_i = wdat; wbs_sel_i = sel;
      for (int i = 0; i < 8 && !acked; i++) begin
         @(posedge wb_clk_i);
         #1;
         if (wbs_ack_o) begin
            acked = 1'b1;
            rdat = wbs_dat_o;
            acc_cyc = cyc_n;
         end
      end
      wbs_stb_i = 1'b0; wbs_cyc_i = 1'b0; wbs_we_i = 1'b0;
   endtask

   task automatic wr(input logic [31:0] adr, input logic [31:0] d);
      logic [31:0] r;
      logic ok;
      wb_xfer(1'b1, adr, d, 4'hF, r, ok);
      chk("wr_ack", {65'h0, ok}, 66'h1);
   endtask

   task automatic rd(input logic [31:0] adr, output logic [31:0] d);
      logic ok;
      wb_xfer(1'b0, adr, 32'h0, 4'hF, d, ok);
      chk("rd_ack", {65'h0, ok}, 66'h1);
   endtask

   task automatic start_sweep(input int first, input int last);
      logic [7:0] prev;
      prev = exp_instr(cyc_n);
      wr(A_CTRL, {8'h00, 8'(last), 8'(first), 8'h01});
      m_prev = prev;
      m_active = 1'b1;
      m_start = acc_cyc;
      m_first = first;
      m_n = last - first + 1;
      m_stop = FAR;
   endtask

   // Poll STATUS until DONE; a 2-cycle gap after the first read puts later reads on odd offsets
   task automatic poll_sweep();
      logic [31:0] d;
      d = 32'h0;
      rd(A_STAT, d);
      chk("status_poll", {34'h0, d}, {34'h0, exp_status(acc_cyc - 1)});
      repeat (2) @(posedge wb_clk_i);
      #1;
      for (int i = 0; i < 400 && !d[1]; i++) begin
         rd(A_STAT, d);
         chk("status_poll", {34'h0, d}, {34'h0, exp_status(acc_cyc - 1)});
      end
      chk("sweep_done_timeout", {65'h0, d[1]}, 66'h1);
   endtask

   task automatic rd_sig(output logic [65:0] s);
      logic [31:0] lo, mid, hi;
      rd(A_SLO, lo);
      rd(A_SMID, mid);
      rd(A_SHI, hi);
      chk("sig_hi_pad", {36'h0, hi[31:2]}, 66'h0);
      s = {hi[1:0], mid, lo};
   endtask

   initial begin
      logic [31:0] d;
      logic [65:0] s;
      logic [65:0] prior_sig;
      logic ok;
      int t0;

      // Reset
      wb_rst_i = 1'b1;
      repeat (2) @(posedge wb_clk_i);
      #1;
      wb_rst_i = 1'b0;
      chk("reset_ack", {65'h0, wbs_ack_o}, 66'h0);
      chk("reset_dat", {34'h0, wbs_dat_o}, 66'h0);
      chk("reset_instr", {58'h0, dec_instr_o}, 66'h0);
      chk_en = 1'b1;
      for (int a = 0; a < 6; a++) begin
         rd(BASE + 32'(4 * a), d);
         chk("reset_reg", {34'h0, d}, 66'h0);
      end
      wb_xfer(1'b0, BASE + 32'h18, 32'h0, 4'hF, d, ok);
      chk("out_of_window_noack", {65'h0, ok}, 66'h0);

      // Handshake: strobe held on STATUS, ack only on cycles 1 and 3
      wbs_stb_i = 1'b1; wbs_cyc_i = 1'b1; wbs_we_i = 1'b0; wbs_adr_i = A_STAT;
      for (int i = 1; i <= 4; i++) begin
         @(posedge wb_clk_i);
         #1;
         chk("ack_pulse", {65'h0, wbs_ack_o}, {65'h0, (i == 1 || i == 3)});
      end
      wbs_stb_i = 1'b0; wbs_cyc_i = 1'b0;
      wb_xfer(1'b1, A_CTRL, 32'h0044_3300, 4'b0001, d, ok);
      chk("sel_write_ack", {65'h0, ok}, 66'h1);
      rd(A_CTRL, d);
      chk("sel_write_ctrl", {34'h0, d}, {34'h0, 32'h0044_3300});

      // Short sweep 0x01..0x02
      start_sweep(1, 2);
      t0 = m_start;
      poll_sweep();
      rd(A_STAT, d);
      chk("short_status", {34'h0, d}, {34'h0, 32'h0002_0202});
      rd_sig(s);
      chk("short_sig", s, 66'h0);
      chk("short_sig_model", sweep_sig(1, 2), 66'h0);

      // Full sweep 0x00..0xFF
      start_sweep(0, 255);
      t0 = m_start;
      poll_sweep();
      rd(A_STAT, d);
      chk("full_status", {34'h0, d}, {34'h0, 32'h00FF_FF02});
      rd_sig(s);
      chk("full_sig", s, sweep_sig(0, 256));
      prior_sig = s;
      wr(A_STAT, 32'hFFFF_FFFF);
      wr(A_RSV, 32'hFFFF_FFFF);
      rd(A_STAT, d);
      chk("ro_write_ignored", {34'h0, d}, {34'h0, 32'h00FF_FF02});
      rd(A_RSV, d);
      chk("reserved_read", {34'h0, d}, 66'h0);

      // Range error FIRST > LAST
      wr(A_CTRL, 32'h000F_1001);
      for (int i = 0; i < 4; i++) begin
         rd(A_STAT, d);
         chk("range_err_status", {34'h0, d}, {34'h0, 32'h00FF_FF06});
      end
      rd_sig(s);
      chk("range_err_sig", s, prior_sig);

      // Abort 40 cycles into a full sweep; a START mid-sweep is ignored
      start_sweep(0, 255);
      t0 = m_start;
      wr(A_CTRL, 32'h0081_8001);
      while (cyc_n < t0 + 39) begin
         @(posedge wb_clk_i);
         #1;
      end
      wr(A_CTRL, 32'h0000_0002);
      m_stop = acc_cyc + 1;
      chk("abort_accept_cycle", 66'(acc_cyc - t0), 66'd40);
      rd(A_STAT, d);
      chk("abort_busy", {65'h0, d[0]}, 66'h0);
      chk("abort_done", {65'h0, d[1]}, 66'h0);
      chk("abort_cur_range", {65'h0, (d[15:8] >= 8'h12 && d[15:8] <= 8'h14)}, 66'h1);
      rd(A_CTRL, d);
      chk("abort_ctrl_kept", {34'h0, d}, {34'h0, 32'h00FF_0000});
      repeat (6) @(posedge wb_clk_i);
      #1;

      // Reset in the middle of a sweep
      start_sweep(8'h20, 8'h30);
      repeat (7) @(posedge wb_clk_i);
      #1;
      chk_en = 1'b0;
      wb_rst_i = 1'b1;
      @(posedge wb_clk_i);
      #1;
      wb_rst_i = 1'b0;
      m_active = 1'b0;
      m_prev = 8'h00;
      chk_en = 1'b1;
      chk("midreset_instr", {58'h0, dec_instr_o}, 66'h0);
      for (int a = 0; a < 5; a++) begin
         rd(BASE + 32'(4 * a), d);
         chk("midreset_reg", {34'h0, d}, 66'h0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
